// File: rtl/pattern_det_prog.sv
// Purpose : programmable serial bit-pattern detector with overlap/non-overlap modes and saturating match count.
// Latency : the match-completing sample is accepted at edge k; DETo is high for the cycle after edge k, and Det_cnt updates at edge k.
// Backpressure: none; Din is sampled only on Din_vld, and idle cycles between samples do not affect detection.
//
// Ports:
//   CLK, nRST        clock (rising edge) and async active-low reset
//   Din, Din_vld     serial bit and its qualifier
//   Pat_ld, Pat_in   reload pattern (MSB = first bit); a sample in the same cycle is discarded
//   Ovl_en           1 = overlapping matches, 0 = restart the window after each match
//   Cnt_clr          synchronous clear of Det_cnt (wins over a coincident increment)
//   DETo             registered one-cycle match pulse
//   Det_cnt          saturating match counter
//   Armed            window holds PAT_LEN valid bits
module pattern_det_prog #(
  parameter int unsigned        PAT_LEN  = 8,
  parameter logic [PAT_LEN-1:0] PAT_INIT = 8'b01101100,
  parameter int unsigned        CNT_W    = 8
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               Din,
  input  logic               Din_vld,
  input  logic               Pat_ld,
  input  logic [PAT_LEN-1:0] Pat_in,
  input  logic               Ovl_en,
  input  logic               Cnt_clr,
  output logic               DETo,
  output logic [CNT_W-1:0]   Det_cnt,
  output logic               Armed
);

  localparam int unsigned        FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0]  FILL_ARM  = FILL_W'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HUNT = 1'b1
  } state_t;

  // Only the newest PAT_LEN-1 bits are kept: the oldest bit of the window
  // would shift out on the next sample before it could ever be compared,
  // so the candidate window is always history plus the incoming bit.
  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  state_t             state_q, state_d;
  logic               deto_q, deto_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic [PAT_LEN-1:0] win;
  logic               match;

  // A load in the same cycle as a valid sample discards the sample.
  assign accept = Din_vld & ~Pat_ld;
  assign win    = {hist_q, Din};
  // fill >= PAT_LEN-1 means this sample completes a full window.
  assign match  = accept && (fill_q >= FILL_ARM) && (win == pat_q);

  always_comb begin
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    state_d = state_q;
    deto_d  = 1'b0;
    cnt_d   = cnt_q;

    if (Pat_ld) begin
      pat_d   = Pat_in;
      hist_d  = '0;
      fill_d  = '0;
      state_d = ST_FILL;
    end else if (accept) begin
      hist_d = win[PAT_LEN-2:0];
      fill_d = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
      if (fill_d == FILL_FULL) begin
        state_d = ST_HUNT;
      end

      if (match) begin
        deto_d = 1'b1;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        // Non-overlap: flush the window so no bit of this match is reused.
        if (!Ovl_en) begin
          hist_d  = '0;
          fill_d  = '0;
          state_d = ST_FILL;
        end
      end
    end

    // Clear takes priority over a coincident increment; DETo is unaffected.
    if (Cnt_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pat_q   <= PAT_INIT;
      hist_q  <= '0;
      fill_q  <= '0;
      state_q <= ST_FILL;
      deto_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      state_q <= state_d;
      deto_q  <= deto_d;
      cnt_q   <= cnt_d;
    end
  end

  assign DETo    = deto_q;
  assign Det_cnt = cnt_q;
  assign Armed   = (state_q == ST_HUNT);

endmodule
